// File: rtl/rgb_channel_merger.sv
// Reassembles RGB pixels from a stream of tagged single-channel samples.
// Each colour lane owns its staging and output register; a two-state FSM sequences collect/emit.

module rgb_merger_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_out
);
  logic [DATA_W-1:0] r_stage;
  logic [DATA_W-1:0] r_out;

  // The completing sample bypasses staging so the pixel leaves on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage <= '0;
      r_out   <= '0;
    end else begin
      if (i_wr)   r_stage <= i_din;
      if (i_load) r_out   <= i_wr ? i_din : r_stage;
    end
  end

  assign o_out = r_out;
endmodule

module rgb_channel_merger #(
  parameter int DATA_W  = 8,
  parameter int COUNT_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  ch_in,
  input  logic [1:0]         ch_sel,
  input  logic               data_valid,
  output logic               data_in_ready,
  input  logic               clear,
  output logic [DATA_W-1:0]  r_out,
  output logic [DATA_W-1:0]  g_out,
  output logic [DATA_W-1:0]  b_out,
  output logic               data_out_valid,
  input  logic               data_out_ready,
  output logic               dup_err,
  output logic [COUNT_W-1:0] pixel_count
);
  localparam int NUM_LANES = 3;

  typedef enum logic {COLLECT, EMIT} state_t;

  state_t                          r_state;
  logic [NUM_LANES-1:0]            r_mask;
  logic                            r_ready;
  logic                            r_valid;
  logic                            r_dup;
  logic [COUNT_W-1:0]              r_count;

  logic                            w_acc;
  logic [NUM_LANES-1:0]            w_bit;
  logic [NUM_LANES-1:0]            w_mask_nxt;
  logic                            w_done;
  logic [NUM_LANES-1:0][DATA_W-1:0] w_pix;

  // Tag 11 and any sample arriving with clear are consumed but never stored.
  assign w_acc      = data_valid & r_ready & ~clear & (ch_sel != 2'b11);
  assign w_bit      = NUM_LANES'(3'b001 << ch_sel);
  assign w_mask_nxt = r_mask | w_bit;
  assign w_done     = w_acc & (&w_mask_nxt);

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      rgb_merger_lane #(.DATA_W(DATA_W)) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_wr   (w_acc & w_bit[g]),
        .i_load (w_done),
        .i_din  (ch_in),
        .o_out  (w_pix[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= COLLECT;
      r_mask  <= '0;
      r_ready <= 1'b1;
      r_valid <= 1'b0;
      r_dup   <= 1'b0;
      r_count <= '0;
    end else begin
      r_dup <= 1'b0;
      case (r_state)
        COLLECT: begin
          if (clear) begin
            r_mask <= '0;
          end else if (w_acc) begin
            r_dup <= |(r_mask & w_bit);
            if (w_done) begin
              r_mask  <= '0;
              r_ready <= 1'b0;
              r_valid <= 1'b1;
              r_state <= EMIT;
            end else begin
              r_mask <= w_mask_nxt;
            end
          end
        end
        EMIT: begin
          if (data_out_ready) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_count <= r_count + COUNT_W'(1);
            r_state <= COLLECT;
          end
        end
        default: r_state <= COLLECT;
      endcase
    end
  end

  assign data_in_ready  = r_ready;
  assign data_out_valid = r_valid;
  assign dup_err        = r_dup;
  assign pixel_count    = r_count;
  assign r_out          = w_pix[0];
  assign g_out          = w_pix[1];
  assign b_out          = w_pix[2];
endmodule
